// File: rtl/axi_write_master_gen.sv
// AXI4 write-master engine: command queue with legality filtering, AW issue under an
// outstanding limit, W beat streaming with generated wlast, and B completion reporting.
module axi_write_master_gen #(
    parameter int IDW     = 4,
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDW-1:0]    cmd_id,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    output logic              cmd_err,
    input  logic [DW-1:0]     wdata_in,
    input  logic [DW/8-1:0]   wstrb_in,
    input  logic              wvalid_in,
    output logic              wready_out,
    output logic [IDW-1:0]    m_axi_awid,
    output logic [AW-1:0]     m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DW-1:0]     m_axi_wdata,
    output logic [DW/8-1:0]   m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [IDW-1:0]    m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              done_valid,
    output logic [IDW-1:0]    done_id,
    output logic [1:0]        done_resp,
    output logic              proto_err
);
    localparam int SZMAX = $clog2(DW/8);
    localparam int PW    = $clog2(MAX_OUT);
    localparam int CW    = PW + 1;
    localparam int CMDW  = IDW + AW + 8 + 3 + 2;

    typedef enum logic {W_IDLE, W_BUSY} wstate_e;

    logic            rdy_q, cmd_err_q, proto_err_q, done_valid_q;
    logic [IDW-1:0]  done_id_q;
    logic [1:0]      done_resp_q;
    logic [CMDW-1:0] cf_mem [MAX_OUT];
    logic [PW-1:0]   cf_wr_q, cf_rd_q;
    logic [CW-1:0]   cf_cnt_q;
    logic [CMDW-1:0] aw_q;
    logic            awvalid_q;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [7:0]      wl_mem [MAX_OUT];
    logic [PW-1:0]   wl_wr_q, wl_rd_q;
    logic [CW-1:0]   wl_cnt_q;
    wstate_e         wst_q;
    logic [7:0]      wlen_q, beat_q;

    logic            cmd_acc, cmd_illegal, cmd_push, cf_empty, cf_full, cf_wr_en, cf_pop;
    logic            can_issue, aw_load, aw_hs, b_hs, b_dec;
    logic [CMDW-1:0] cmd_in, aw_src;
    logic            wl_empty, w_busy, w_hs, need_len, wl_pop, wl_bypass, wl_push;

    assign cmd_in   = {cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst};
    assign cf_empty = (cf_cnt_q == '0);
    assign cf_full  = (cf_cnt_q == CW'(MAX_OUT));
    assign cmd_ready = rdy_q && !cf_full;
    assign cmd_acc   = cmd_valid && cmd_ready;

    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_size > 3'(SZMAX))                                           cmd_illegal = 1'b1;
        if (cmd_burst == 2'b11)                                             cmd_illegal = 1'b1;
        if (cmd_burst == 2'b10 && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) cmd_illegal = 1'b1;
        if (cmd_burst == 2'b00 && cmd_len > 8'd15)                          cmd_illegal = 1'b1;
    end

    assign cmd_push  = cmd_acc && !cmd_illegal;
    assign can_issue = ({1'b0, out_cnt_q} + (CW+1)'(awvalid_q)) < (CW+1)'(MAX_OUT)
                       && (!awvalid_q || m_axi_awready);
    // An empty queue lets a fresh command go straight to the AW registers.
    assign aw_load   = can_issue && (!cf_empty || cmd_push);
    assign aw_src    = cf_empty ? cmd_in : cf_mem[cf_rd_q];
    assign cf_pop    = can_issue && !cf_empty;
    assign cf_wr_en  = cmd_push && !(cf_empty && can_issue);
    assign aw_hs     = awvalid_q && m_axi_awready;
    assign b_hs      = m_axi_bvalid && rdy_q;
    assign b_dec     = b_hs && (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (aw_hs && !b_dec)      out_cnt_d = out_cnt_q + CW'(1);
        else if (!aw_hs && b_dec) out_cnt_d = out_cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (cf_wr_en) cf_mem[cf_wr_q] <= cmd_in;
        if (wl_push)  wl_mem[wl_wr_q] <= m_axi_awlen;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q        <= 1'b0;
            cmd_err_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_resp_q  <= '0;
            cf_wr_q      <= '0;
            cf_rd_q      <= '0;
            cf_cnt_q     <= '0;
            aw_q         <= '0;
            awvalid_q    <= 1'b0;
            out_cnt_q    <= '0;
        end else begin
            rdy_q        <= 1'b1;
            cmd_err_q    <= cmd_acc && cmd_illegal;
            proto_err_q  <= proto_err_q || (b_hs && out_cnt_q == '0);
            done_valid_q <= b_hs;
            if (b_hs) begin
                done_id_q   <= m_axi_bid;
                done_resp_q <= m_axi_bresp;
            end
            if (cf_wr_en) cf_wr_q <= cf_wr_q + PW'(1);
            if (cf_pop)   cf_rd_q <= cf_rd_q + PW'(1);
            if (cf_wr_en && !cf_pop)      cf_cnt_q <= cf_cnt_q + CW'(1);
            else if (!cf_wr_en && cf_pop) cf_cnt_q <= cf_cnt_q - CW'(1);
            if (aw_load) begin
                aw_q      <= aw_src;
                awvalid_q <= 1'b1;
            end else if (m_axi_awready) begin
                awvalid_q <= 1'b0;
            end
            out_cnt_q <= out_cnt_d;
        end
    end

    assign wl_empty  = (wl_cnt_q == '0);
    assign w_busy    = (wst_q == W_BUSY);
    assign w_hs      = w_busy && wvalid_in && m_axi_wready;
    assign need_len  = !w_busy || (w_hs && beat_q == wlen_q);
    assign wl_pop    = need_len && !wl_empty;
    // A length arriving while the W side is waiting skips the FIFO so W can start next cycle.
    assign wl_bypass = need_len && wl_empty && aw_hs;
    assign wl_push   = aw_hs && !wl_bypass;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wst_q    <= W_IDLE;
            wlen_q   <= '0;
            beat_q   <= '0;
            wl_wr_q  <= '0;
            wl_rd_q  <= '0;
            wl_cnt_q <= '0;
        end else begin
            if (wl_push) wl_wr_q <= wl_wr_q + PW'(1);
            if (wl_pop)  wl_rd_q <= wl_rd_q + PW'(1);
            if (wl_push && !wl_pop)      wl_cnt_q <= wl_cnt_q + CW'(1);
            else if (!wl_push && wl_pop) wl_cnt_q <= wl_cnt_q - CW'(1);
            if (need_len) begin
                beat_q <= '0;
                if (wl_pop) begin
                    wst_q  <= W_BUSY;
                    wlen_q <= wl_mem[wl_rd_q];
                end else if (wl_bypass) begin
                    wst_q  <= W_BUSY;
                    wlen_q <= m_axi_awlen;
                end else begin
                    wst_q  <= W_IDLE;
                end
            end else if (w_hs) begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} = aw_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_in;
    assign m_axi_wstrb   = wstrb_in;
    assign m_axi_wvalid  = w_busy && wvalid_in;
    assign wready_out    = w_busy && m_axi_wready;
    assign m_axi_wlast   = w_busy && (beat_q == wlen_q);
    assign m_axi_bready  = rdy_q;
    assign cmd_err       = cmd_err_q;
    assign done_valid    = done_valid_q;
    assign done_id       = done_id_q;
    assign done_resp     = done_resp_q;
    assign proto_err     = proto_err_q;
endmodule

// File: tb/tb_axi_write_master_gen.sv
// Directed bench for axi_write_master_gen: table of commands plus hand-written
// sequences for W backpressure, outstanding limit, simultaneous AW/B, protocol error and reset.
module tb_axi_write_master_gen;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid, cmd_ready, cmd_err;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [63:0] wdata_in;
    logic [7:0]  wstrb_in;
    logic        wvalid_in, wready_out;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic        proto_err;

    int n_chk = 0;
    int n_err = 0;

    axi_write_master_gen #(.IDW(4), .AW(32), .DW(64), .MAX_OUT(4)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_err(cmd_err),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in), .wready_out(wready_out),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        wdata_in = '0; wstrb_in = '0; wvalid_in = 1'b0;
        awready = 1'b1; wready = 1'b1; bid = '0; bresp = '0; bvalid = 1'b0;
    endtask

    task automatic set_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_size = size; cmd_burst = burst;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        step(); step(); step();
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", cmd_ready, 1'b0);
        step();
        @(negedge clk);
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);
        chk("bready_after_rst", bready, 1'b1);
        step();
    endtask

    // Full transaction for one table record; starts and ends at posedge+1.
    task automatic apply_vec(input vec_t v);
        set_cmd(v.id, v.addr, v.len, v.size, v.burst);
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("cmd_err", cmd_err, v.err);
        chk("awvalid", awvalid, !v.err);
        if (v.err) begin
            step();
            @(negedge clk);
            chk("cmd_err_pulse", cmd_err, 1'b0);
            chk("no_aw", awvalid, 1'b0);
            chk("cmd_ready_kept", cmd_ready, 1'b1);
            step();
        end else begin
            chk("awid", awid, v.id);
            chk("awaddr", awaddr, v.addr);
            chk("awlen", awlen, v.len);
            chk("awsize", awsize, v.size);
            chk("awburst", awburst, v.burst);
            step();
            @(negedge clk);
            chk("awvalid_drop", awvalid, 1'b0);
            chk("wvalid_pre", wvalid, 1'b0);
            chk("wready_out_busy", wready_out, 1'b1);
            for (int b = 0; b <= int'(v.len); b++) begin
                wvalid_in = 1'b1;
                wdata_in = {v.addr, 32'(b)};
                wstrb_in = 8'hFF ^ 8'(b);
                #1;
                chk("wvalid", wvalid, 1'b1);
                chk("wlast", wlast, b == int'(v.len));
                chk("wdata", wdata, {v.addr, 32'(b)});
                step();
            end
            wvalid_in = 1'b0;
            @(negedge clk);
            chk("wlast_idle", wlast, 1'b0);
            chk("wready_out_idle", wready_out, 1'b0);
            chk("done_early", done_valid, 1'b0);
            bvalid = 1'b1; bid = v.id; bresp = v.resp;
            step();
            bvalid = 1'b0;
            @(negedge clk);
            chk("done_valid", done_valid, 1'b1);
            chk("done_id", done_id, v.id);
            chk("done_resp", done_resp, v.resp);
            chk("proto_ok", proto_err, 1'b0);
            step();
            @(negedge clk);
            chk("done_pulse", done_valid, 1'b0);
            step();
        end
    endtask

    initial begin
        int beats, acc, aws;
        logic [3:0] lastmap;
        vec_t fresh;

        vecs[0] = '{4'd3,  32'h100,  8'd3,  3'd3, 2'b01, 2'b00, 1'b0};
        vecs[1] = '{4'd1,  32'h200,  8'd0,  3'd4, 2'b01, 2'b00, 1'b1};
        vecs[2] = '{4'd2,  32'h300,  8'd1,  3'd3, 2'b11, 2'b00, 1'b1};
        vecs[3] = '{4'd4,  32'h400,  8'd5,  3'd3, 2'b10, 2'b00, 1'b1};
        vecs[4] = '{4'd5,  32'h520,  8'd7,  3'd2, 2'b10, 2'b01, 1'b0};
        vecs[5] = '{4'd6,  32'h600,  8'd16, 3'd0, 2'b00, 2'b00, 1'b1};
        vecs[6] = '{4'd7,  32'h700,  8'd15, 3'd0, 2'b00, 2'b11, 1'b0};
        vecs[7] = '{4'hF,  32'h800,  8'd0,  3'd3, 2'b01, 2'b10, 1'b0};

        resetn = 1'b0;
        idle_inputs();
        #1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wready_out", wready_out, 1'b0);
        do_reset();

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Two bursts (len 0 and 2) with wready toggling every cycle.
        wvalid_in = 1'b1; wready = 1'b0; wdata_in = 64'hA5;
        set_cmd(4'd1, 32'h1000, 8'd0, 3'd3, 2'b01);
        step();
        set_cmd(4'd2, 32'h2000, 8'd2, 3'd3, 2'b01);
        step();
        cmd_valid = 1'b0;
        beats = 0; lastmap = '0;
        for (int c = 0; c < 30 && beats < 4; c++) begin
            wready = ~wready;
            @(negedge clk);
            if (wvalid && wready) begin
                lastmap[beats] = wlast;
                beats++;
            end
            step();
        end
        wready = 1'b1;
        chk("toggle_beats", 64'(beats), 64'd4);
        chk("toggle_wlast_map", lastmap, 4'b1001);
        @(negedge clk);
        chk("toggle_no_extra", wvalid, 1'b0);
        wvalid_in = 1'b0;
        bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
        step();
        bid = 4'd2; bresp = 2'b01;
        @(negedge clk);
        chk("toggle_done1", done_id, 4'd1);
        step();
        bvalid = 1'b0;
        @(negedge clk);
        chk("toggle_done2_id", done_id, 4'd2);
        chk("toggle_done2_resp", done_resp, 2'b01);
        step();

        // AW handshake coinciding with a B handshake leaves the outstanding count alone.
        wvalid_in = 1'b1;
        set_cmd(4'd5, 32'h3000, 8'd0, 3'd3, 2'b01);
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        set_cmd(4'd6, 32'h3100, 8'd0, 3'd3, 2'b01);
        step();
        cmd_valid = 1'b0;
        bvalid = 1'b1; bid = 4'd5;
        @(negedge clk);
        chk("sim_awvalid", awvalid, 1'b1);
        step();
        bvalid = 1'b0;
        @(negedge clk);
        chk("sim_done_id", done_id, 4'd5);
        chk("sim_proto", proto_err, 1'b0);
        step(); step();
        bvalid = 1'b1; bid = 4'd6;
        step();
        bvalid = 1'b0;
        @(negedge clk);
        chk("sim_last_b_proto", proto_err, 1'b0);
        chk("sim_last_b_id", done_id, 4'd6);
        step();
        bvalid = 1'b1; bid = 4'd7;
        step();
        bvalid = 1'b0;
        @(negedge clk);
        chk("proto_set", proto_err, 1'b1);
        chk("proto_done", done_valid, 1'b1);
        step(); step(); step();
        @(negedge clk);
        chk("proto_sticky", proto_err, 1'b1);
        wvalid_in = 1'b0;
        step();

        // Outstanding limit: eight commands, no B responses.
        acc = 0; aws = 0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            set_cmd(4'(acc), 32'(acc * 64), 8'd0, 3'd3, 2'b01);
            @(negedge clk);
            if (awvalid && awready) aws++;
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (awvalid && awready) aws++;
            step();
        end
        chk("lim_accepted", 64'(acc), 64'd8);
        chk("lim_aw_count", 64'(aws), 64'd4);
        @(negedge clk);
        chk("lim_cmd_ready_full", cmd_ready, 1'b0);
        bvalid = 1'b1; bid = 4'd0;
        step();
        bvalid = 1'b0;
        aws = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (awvalid && awready) aws++;
            step();
        end
        chk("lim_one_more_aw", 64'(aws), 64'd1);
        @(negedge clk);
        chk("lim_cmd_ready_back", cmd_ready, 1'b1);
        step();
        do_reset();
        chk("rst_clears_proto", proto_err, 1'b0);

        // Reset during beat 2 of a 4-beat burst.
        set_cmd(4'd9, 32'h200, 8'd3, 3'd3, 2'b01);
        step();
        cmd_valid = 1'b0;
        step();
        wvalid_in = 1'b1;
        step();
        @(negedge clk);
        chk("mid_wvalid", wvalid, 1'b1);
        chk("mid_wlast", wlast, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk("mid_awvalid", awvalid, 1'b0);
        chk("mid_wvalid_rst", wvalid, 1'b0);
        chk("mid_wlast_rst", wlast, 1'b0);
        chk("mid_wready_out", wready_out, 1'b0);
        chk("mid_bready", bready, 1'b0);
        chk("mid_cmd_ready", cmd_ready, 1'b0);
        chk("mid_cmd_err", cmd_err, 1'b0);
        chk("mid_done", done_valid, 1'b0);
        chk("mid_proto", proto_err, 1'b0);
        chk("mid_aw_fields", {awid, awaddr, awlen}, 44'h0);
        step(); step();
        resetn = 1'b1;
        step();
        @(negedge clk);
        chk("mid_post_ready", cmd_ready, 1'b1);
        chk("mid_post_wvalid", wvalid, 1'b0);
        chk("mid_post_done", done_valid, 1'b0);
        wvalid_in = 1'b0;
        step();
        fresh = '{4'd10, 32'h900, 8'd3, 3'd3, 2'b01, 2'b00, 1'b0};
        apply_vec(fresh);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
